// File: rtl/fixed_point_divider.sv
// fixed_point_divider: multi-cycle signed fixed-point restoring divider with N/V/Z flags.
// Define FXDIV_ROUND_EN to round half-away-from-zero using one extra guard quotient bit.
module fixed_point_divider #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] Out,
    output logic                  N,
    output logic                  V,
    output logic                  Z
);
`ifdef FXDIV_ROUND_EN
    localparam int RB = 1;
`else
    localparam int RB = 0;
`endif
    localparam int L  = DATA_WIDTH + FRAC_BITS;
    localparam int QW = L + RB;
    localparam int CW = $clog2(QW + 1);
    localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3;
    localparam logic [DATA_WIDTH-1:0] MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [QW:0] POS_LIM = (QW+1)'(MAX);
    localparam logic [QW:0] NEG_LIM = (QW+1)'(MIN);

    logic [1:0]            state;
    logic [CW-1:0]         cnt;
    logic                  sign, div0, a_neg, a_zero, fits, res_v, accept;
    logic [DATA_WIDTH-1:0] rem, bmag, amag, bmag_in, rem_n, res;
    logic [DATA_WIDTH:0]   t;
    logic [QW-1:0]         quo;
    logic [QW:0]           mag;

    assign in_ready  = rst_n & (state == IDLE | (state == DONE & out_ready));
    assign accept    = in_valid & in_ready;
    assign out_valid = state == DONE;
    assign amag      = A[DATA_WIDTH-1] ? -A : A;
    assign bmag_in   = B[DATA_WIDTH-1] ? -B : B;
    // Remainder stays below |B| <= 2^(DATA_WIDTH-1), so the subtraction never needs the top bit.
    assign t         = {rem, quo[QW-1]};
    assign fits      = t >= {1'b0, bmag};
    assign rem_n     = fits ? t[DATA_WIDTH-1:0] - bmag : t[DATA_WIDTH-1:0];
    assign mag       = ({1'b0, quo} + (QW+1)'(RB)) >> RB;
    assign res       = div0 ? (a_zero ? '0 : a_neg ? MIN : MAX)
                     : sign ? (mag > NEG_LIM ? MIN : -mag[DATA_WIDTH-1:0])
                     : (mag > POS_LIM ? MAX : mag[DATA_WIDTH-1:0]);
    assign res_v     = div0 | (sign ? mag > NEG_LIM : mag > POS_LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            sign   <= 1'b0;
            div0   <= 1'b0;
            a_neg  <= 1'b0;
            a_zero <= 1'b0;
            rem    <= '0;
            bmag   <= '0;
            quo    <= '0;
            Out    <= '0;
            N      <= 1'b0;
            V      <= 1'b0;
            Z      <= 1'b0;
        end else if (accept) begin
            state  <= CALC;
            cnt    <= '0;
            sign   <= A[DATA_WIDTH-1] ^ B[DATA_WIDTH-1];
            div0   <= B == '0;
            a_neg  <= A[DATA_WIDTH-1];
            a_zero <= A == '0;
            rem    <= '0;
            bmag   <= bmag_in;
            quo    <= {amag, {(FRAC_BITS+RB){1'b0}}};
        end else begin
            case (state)
                CALC: if (cnt < CW'(QW)) begin
                    rem <= rem_n;
                    quo <= {quo[QW-2:0], fits};
                    cnt <= cnt + 1'b1;
                end else state <= FIX;
                FIX: begin
                    Out   <= res;
                    N     <= res[DATA_WIDTH-1];
                    V     <= res_v;
                    Z     <= res == '0;
                    state <= DONE;
                end
                DONE: if (out_ready) state <= IDLE;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fixed_point_divider.sv
// tb_fixed_point_divider: random and directed stimulus against an arithmetic reference model.
module tb_fixed_point_divider;
`ifdef FXDIV_ROUND_EN
    localparam int RB = 1;
`else
    localparam int RB = 0;
`endif
    localparam int LAT = 24 + RB + 2;
    localparam logic [15:0] RND1 = (RB == 1) ? 16'h0001 : 16'h0000;

    typedef struct packed {logic [15:0] o; logic n, v, z;} res_t;
    typedef struct {res_t r; int acc;} ent_t;

    logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 1;
    logic [15:0] A = 0, B = 0;
    logic in_ready, out_valid, N, V, Z;
    logic [15:0] Out;
    int errors = 0, checks = 0, cyc = 0;
    bit rnd_on;
    ent_t q[$];

    fixed_point_divider dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
        .Out(Out), .N(N), .V(V), .Z(Z)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic res_t model(input logic [15:0] a, input logic [15:0] b);
        res_t r;
        longint ai, bi, m;
        bit neg;
        ai = longint'($signed(a));
        bi = longint'($signed(b));
        r.v = 1'b0;
        if (bi == 0) begin
            r.v = 1'b1;
            r.o = ai > 0 ? 16'h7fff : ai < 0 ? 16'h8000 : 16'h0000;
        end else begin
            m = ((ai < 0 ? -ai : ai) * (longint'(256) << RB)) / (bi < 0 ? -bi : bi);
            if (RB == 1) m = (m + 1) / 2;
            neg = (ai < 0) != (bi < 0);
            if (neg) begin
                if (m > 32768) begin r.o = 16'h8000; r.v = 1'b1; end
                else r.o = 16'(-m);
            end else begin
                if (m > 32767) begin r.o = 16'h7fff; r.v = 1'b1; end
                else r.o = 16'(m);
            end
        end
        r.n = r.o[15];
        r.z = r.o == 16'h0;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Predicts each handshake at the negedge before the edge that takes it.
    always @(negedge clk) begin : mon
        bit due;
        ent_t e;
        if (!rst_n) q.delete();
        else begin
            due = q.size() > 0 && (cyc - q[0].acc >= LAT);
            chk("out_valid", out_valid, due);
            chk("in_ready", in_ready, q.size() == 0 || (due && out_ready));
            if (due) begin
                chk("Out", Out, q[0].r.o);
                chk("N", N, q[0].r.n);
                chk("V", V, q[0].r.v);
                chk("Z", Z, q[0].r.z);
                if (out_ready) void'(q.pop_front());
            end
            if (in_valid && in_ready) begin
                e.r = model(A, B);
                e.acc = cyc + 1;
                q.push_back(e);
            end
        end
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b, output int waits);
        A = a;
        B = b;
        in_valid = 1;
        waits = 0;
        do begin @(negedge clk); waits++; end while (!in_ready && waits < 200);
        chk("accept_timeout", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 0;
        A = 16'($urandom);
        B = 16'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (q.size() != 0 && n < 200) begin @(negedge clk); n++; end
        chk("drain", q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!out_valid && n < 100) begin @(negedge clk); n++; end
        chk("wait_valid", out_valid, 1);
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 7))
            0: return 16'h0000;
            1: return 16'h8000;
            2: return 16'h7fff;
            3: return 16'h0100;
            4: return 16'hff00;
            5: return 16'($urandom_range(1, 3));
            default: return 16'($urandom);
        endcase
    endfunction

    logic [15:0] da[11] = '{16'h0A00, 16'hFB80, 16'hFB80, 16'h7F00, 16'h8000, 16'h8000,
                            16'h0100, 16'hFF00, 16'h0000, 16'h0001, 16'hFFFF};
    logic [15:0] db[11] = '{16'h0400, 16'h0200, 16'hFE00, 16'h0080, 16'hFF00, 16'h0100,
                            16'h0000, 16'h0000, 16'h0000, 16'h0200, 16'h7FFF};
    logic [15:0] dq[11] = '{16'h0280, 16'hFDC0, 16'h0240, 16'h7FFF, 16'h7FFF, 16'h8000,
                            16'h7FFF, 16'h8000, 16'h0000, RND1,    16'h0000};
    logic        dv[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    initial begin
        int w;
        res_t r;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_Out", Out, 0);
        chk("rst_NVZ", {N, V, Z}, 0);
        rst_n = 1;
        #1 chk("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 11; i++) begin
            r = model(da[i], db[i]);
            chk("pin_o", r.o, dq[i]);
            chk("pin_v", r.v, dv[i]);
            send(da[i], db[i], w);
            wait_idle();
        end
        out_ready = 0;
        send(16'h0A00, 16'h0400, w);
        wait_valid();
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1 out_ready = 1;
        send(16'h0600, 16'h0200, w);
        chk("b2b_same_edge", w, 1);
        wait_idle();
        send(16'h0A00, 16'h0400, w);
        repeat (10) @(posedge clk);
        #1 rst_n = 0;
        #1;
        chk("calc_rst_valid", out_valid, 0);
        chk("calc_rst_Out", Out, 0);
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1;
        #1 chk("calc_rst_ready", in_ready, 1);
        @(posedge clk);
        #1 out_ready = 0;
        send(16'h0300, 16'h0100, w);
        wait_valid();
        #2 rst_n = 0;
        #1;
        chk("done_rst_valid", out_valid, 0);
        chk("done_rst_Out", Out, 0);
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1;
        out_ready = 1;
        @(posedge clk);
        #1;
        rnd_on = 1;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    send(pick(), pick(), w);
                end
                rnd_on = 0;
            end
            begin
                while (rnd_on) begin
                    @(posedge clk);
                    #1 out_ready = $urandom_range(0, 3) != 0;
                end
            end
        join
        out_ready = 1;
        wait_idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
